// File: rtl/axi4lite_pkg.sv
// Shared types and address decode for the AXI4-Lite register slave.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef struct packed {
    logic [31:0] idx;
    logic        err;
  } dec_t;

  // Byte address -> register index; err on below-base, out-of-range or misaligned.
  function automatic dec_t addr_decode(input logic [63:0] addr, input logic [63:0] base,
                                       input int unsigned addr_w, input int unsigned num_regs,
                                       input int unsigned data_w);
    logic [63:0] mask;
    logic [63:0] off;
    logic [63:0] idx;
    int unsigned lsb;
    dec_t        d;
    mask  = (addr_w >= 32'd64) ? '1 : ((64'd1 << addr_w) - 64'd1);
    off   = (addr - base) & mask;
    lsb   = (data_w == 32'd64) ? 32'd3 : 32'd2;
    idx   = off >> lsb;
    d.idx = idx[31:0];
    d.err = (addr < base) || (idx >= 64'(num_regs)) ||
            ((off & ((64'd1 << lsb) - 64'd1)) != 64'd0);
    return d;
  endfunction

endpackage

// File: rtl/axi_lite_hold_buf.sv
// One-entry valid/ready holding register; READY depends only on flops and en.
module axi_lite_hold_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         valid,
  output logic         ready_c,
  input  logic [W-1:0] din,
  input  logic         clr,
  output logic         full,
  output logic [W-1:0] dout
);

  assign ready_c = en & ~full & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clr) begin
      full <= 1'b0;
    end else if (valid && ready_c) begin
      full <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/axi4lite_wr_slave_regs.sv
// AXI4-Lite write-only slave: independent AW/W hold buffers, strobed register file, B channel.
module axi4lite_wr_slave_regs
  import axi4lite_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [DATA_W-1:0]  RST_VAL   = '0,
  localparam int unsigned       STRB_W    = DATA_W / 8,
  localparam int unsigned       IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic                       WVALID,
  output logic                       WREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [STRB_W-1:0]          WSTRB,
  output logic                       BVALID,
  input  logic                       BREADY,
  output logic [1:0]                 BRESP,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_pulse_o,
  output logic [IDX_W-1:0]           wr_idx_o
);

  logic                     aw_full;
  logic                     w_full;
  logic [ADDR_W-1:0]        aw_q;
  logic [DATA_W-1:0]        wdata_q;
  logic [STRB_W-1:0]        wstrb_q;
  logic                     commit_c;
  dec_t                     dec_c;
  resp_t                    bresp_q;
  logic [DATA_W-1:0]        regs_q [NUM_REGS];

  axi_lite_hold_buf #(.W(ADDR_W)) u_aw_buf (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .valid   (AWVALID),
    .ready_c (AWREADY),
    .din     (AWADDR),
    .clr     (commit_c),
    .full    (aw_full),
    .dout    (aw_q)
  );

  axi_lite_hold_buf #(.W(DATA_W + STRB_W)) u_w_buf (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .valid   (WVALID),
    .ready_c (WREADY),
    .din     ({WSTRB, WDATA}),
    .clr     (commit_c),
    .full    (w_full),
    .dout    ({wstrb_q, wdata_q})
  );

  // A write commits only when the B slot is free or being drained this edge.
  assign commit_c = aw_full & w_full & (~BVALID | BREADY);
  assign dec_c    = addr_decode(64'(aw_q), 64'(BASE_ADDR), ADDR_W, NUM_REGS, DATA_W);
  assign BRESP    = bresp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BVALID     <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_o <= 1'b0;
      wr_idx_o   <= '0;
    end else begin
      wr_pulse_o <= 1'b0;
      if (commit_c) begin
        BVALID  <= 1'b1;
        bresp_q <= dec_c.err ? RESP_SLVERR : RESP_OKAY;
        if (!dec_c.err) begin
          wr_pulse_o <= 1'b1;
          wr_idx_o   <= IDX_W'(dec_c.idx);
        end
      end else if (BVALID && BREADY) begin
        BVALID <= 1'b0;
      end
    end
  end

  // Byte-strobed register file update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
    end else if (commit_c && !dec_c.err) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dec_c.idx == 32'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) regs_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_axi4lite_wr_slave_regs.sv
// Scoreboard bench: two slaves (base 0x0 and 0x1000) on one shared write bus.
module tb_axi4lite_wr_slave_regs;

  localparam logic [31:0] RV = 32'hA5A5_A5A5;

  typedef struct {
    logic [1:0] ra;
    logic [1:0] rb;
    bit         pa;
    bit         pb;
    logic [3:0] ia;
    logic [3:0] ib;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        AWVALID = 1'b0;
  logic [31:0] AWADDR = '0;
  logic        WVALID = 1'b0;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        BREADY = 1'b1;

  logic         awready_a, wready_a, bvalid_a, pulse_a;
  logic         awready_b, wready_b, bvalid_b, pulse_b;
  logic [1:0]   bresp_a, bresp_b;
  logic [3:0]   idx_a, idx_b;
  logic [511:0] regs_a, regs_b;

  int checks = 0;
  int errors = 0;
  exp_t       bq[$];
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic [31:0] model_a [16];
  logic [31:0] model_b [16];

  always #5 clk = ~clk;

  axi4lite_wr_slave_regs #(.BASE_ADDR(32'h0), .RST_VAL(RV)) dut_a (
    .clk(clk), .rst(rst), .en(en),
    .AWVALID(AWVALID), .AWREADY(awready_a), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(wready_a), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(bvalid_a), .BREADY(BREADY), .BRESP(bresp_a),
    .regs_o(regs_a), .wr_pulse_o(pulse_a), .wr_idx_o(idx_a)
  );

  axi4lite_wr_slave_regs #(.BASE_ADDR(32'h1000), .RST_VAL(RV)) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .AWVALID(AWVALID), .AWREADY(awready_b), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(wready_b), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(bvalid_b), .BREADY(BREADY), .BRESP(bresp_b),
    .regs_o(regs_b), .wr_pulse_o(pulse_b), .wr_idx_o(idx_b)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      model_a[i] = RV;
      model_b[i] = RV;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_a_reg%0d", tag, i), 64'(regs_a[i*32 +: 32]), 64'(model_a[i]));
      chk($sformatf("%s_b_reg%0d", tag, i), 64'(regs_b[i*32 +: 32]), 64'(model_b[i]));
    end
  endtask

  // Drives one write; AW/W start after their own delays, en forced low in [en_lo, en_hi).
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int en_lo, input int en_hi,
                          input exp_t e);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_f, w_f;
    int c = 0;
    bq.push_back(e);
    if (e.pa) begin
      qa.push_back(e.ia);
      model_a[e.ia] = merge(model_a[e.ia], data, strb);
    end
    if (e.pb) begin
      qb.push_back(e.ib);
      model_b[e.ib] = merge(model_b[e.ib], data, strb);
    end
    while (!(aw_done && w_done) && c < 100) begin
      AWVALID = !aw_done && (c >= aw_dly);
      AWADDR  = addr;
      WVALID  = !w_done && (c >= w_dly);
      WDATA   = data;
      WSTRB   = strb;
      en      = !(c >= en_lo && c < en_hi);
      @(negedge clk);
      if (!en) begin
        chk("en_low_awready", 64'(awready_a), 64'd0);
        chk("en_low_wready", 64'(wready_a), 64'd0);
      end
      if (w_done && !aw_done) chk("w_held_wready", 64'(wready_a), 64'd0);
      if (aw_done && !w_done) chk("aw_held_awready", 64'(awready_a), 64'd0);
      aw_f = AWVALID && awready_a;
      w_f  = WVALID && wready_a;
      @(posedge clk);
      #1;
      if (aw_f) aw_done = 1;
      if (w_f) w_done = 1;
      c++;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    en      = 1'b1;
    if (!(aw_done && w_done)) chk("write_timeout", 64'd1, 64'd0);
  endtask

  // Monitor: B responses, B stability under backpressure, and write pulses.
  bit         prev_hold = 0;
  logic [1:0] prev_ra, prev_rb;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("b_stable_valid", 64'({bvalid_a, bvalid_b}), 64'(2'b11));
        chk("b_stable_resp", 64'({bresp_a, bresp_b}), 64'({prev_ra, prev_rb}));
      end
      if (bvalid_a && BREADY) begin
        if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = bq.pop_front();
          chk("bresp_a", 64'(bresp_a), 64'(e.ra));
          chk("bresp_b", 64'({bvalid_b, bresp_b}), 64'({1'b1, e.rb}));
        end
      end
      prev_hold = bvalid_a && !BREADY;
      prev_ra   = bresp_a;
      prev_rb   = bresp_b;
      if (pulse_a) begin
        if (qa.size() == 0) chk("pulse_a_unexpected", 64'd1, 64'd0);
        else chk("wr_idx_a", 64'(idx_a), 64'(qa.pop_front()));
      end
      if (pulse_b) begin
        if (qb.size() == 0) chk("pulse_b_unexpected", 64'd1, 64'd0);
        else chk("wr_idx_b", 64'(idx_b), 64'(qb.pop_front()));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bvalid"}, 64'({bvalid_a, bvalid_b}), 64'd0);
    chk({tag, "_bresp"}, 64'({bresp_a, bresp_b}), 64'd0);
    chk({tag, "_ready"}, 64'({awready_a, wready_a, awready_b, wready_b}), 64'd0);
    chk({tag, "_pulse_idx"}, 64'({pulse_a, idx_a, pulse_b, idx_b}), 64'd0);
    chk({tag, "_reg0"}, 64'(regs_a[31:0]), 64'(RV));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: same-cycle AW/W, full strobe, latency check
    do_write(32'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, '{2'b00, 2'b10, 1, 0, 4'd2, 4'd0});
    @(negedge clk);
    chk("lat_bvalid_n1", 64'(bvalid_a), 64'd0);
    @(negedge clk);
    chk("lat_bvalid_n2", 64'(bvalid_a), 64'd1);
    @(posedge clk); #1;

    // 2: W first, AW three cycles later, partial strobe over RST_VAL
    do_write(32'h04, 32'h1122_3344, 4'b0101, 3, 0, 0, 0, '{2'b00, 2'b10, 1, 0, 4'd1, 4'd0});
    repeat (3) @(posedge clk); #1;
    chk("t2_reg1", 64'(regs_a[63:32]), 64'(32'hA522_A544));

    // en low while W is held, AW accepted after en returns
    do_write(32'h1C, 32'h0000_FFFF, 4'b0011, 4, 0, 1, 4, '{2'b00, 2'b10, 1, 0, 4'd7, 4'd0});
    // zero strobe: OKAY and pulse, no data change
    do_write(32'h14, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 0, '{2'b00, 2'b10, 1, 0, 4'd5, 4'd0});

    // 3: out of range and misaligned
    do_write(32'h40, 32'h1234_5678, 4'hF, 0, 1, 0, 0, '{2'b10, 2'b10, 0, 0, 4'd0, 4'd0});
    do_write(32'h06, 32'h1234_5678, 4'hF, 1, 0, 0, 0, '{2'b10, 2'b10, 0, 0, 4'd0, 4'd0});
    repeat (3) @(posedge clk); #1;

    // 4: back-to-back under BREADY backpressure
    BREADY = 1'b0;
    do_write(32'h100C, 32'h0102_0304, 4'hF, 0, 0, 0, 0, '{2'b10, 2'b00, 0, 1, 4'd0, 4'd3});
    do_write(32'h3C, 32'hCAFE_F00D, 4'b1100, 0, 0, 0, 0, '{2'b00, 2'b10, 1, 0, 4'd15, 4'd0});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready_low", 64'({awready_a, wready_a}), 64'd0);
      @(posedge clk); #1;
    end
    BREADY = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("t4_reg15", 64'(regs_a[511:480]), 64'(32'hCAFE_A5A5));

    // 5: base 0x1000 decode
    do_write(32'h0FFC, 32'hAAAA_5555, 4'hF, 0, 0, 0, 0, '{2'b10, 2'b10, 0, 0, 4'd0, 4'd0});
    do_write(32'h1004, 32'h5566_7788, 4'hF, 0, 0, 0, 0, '{2'b10, 2'b00, 0, 1, 4'd0, 4'd1});
    repeat (4) @(posedge clk); #1;
    check_regs("pre_rst");

    // 6: reset with B pending and AW held
    BREADY = 1'b0;
    do_write(32'h20, 32'h1234_5678, 4'hF, 0, 0, 0, 0, '{2'b00, 2'b10, 1, 0, 4'd8, 4'd0});
    repeat (2) @(posedge clk); #1;
    AWVALID = 1'b1;
    AWADDR  = 32'h24;
    @(negedge clk);
    chk("t6_aw_accept", 64'(awready_a), 64'd1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    @(negedge clk);
    chk("t6_bvalid_before", 64'(bvalid_a), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    bq.delete();
    qa.delete();
    qb.delete();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    BREADY = 1'b1;
    check_regs("post_rst");
    do_write(32'h24, 32'hFFEE_DDCC, 4'hF, 0, 0, 0, 0, '{2'b00, 2'b10, 1, 0, 4'd9, 4'd0});
    repeat (5) @(posedge clk); #1;
    check_regs("final");
    chk("queues_drained", 64'(bq.size() + qa.size() + qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d want 0", 1);
    $fatal(1, "timeout");
  end

endmodule
